cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Host-side sequencer for the 5-stage RISC-V cpu. Streams a program into instruction
//  memory over the external port, resets the pipeline, then runs the core by driving
//  its enable. Stops on a halt request or a cycle budget, drains in-flight instructions,
//  and reports done/timeout plus the run cycle count. Sits between testbench/host and cpu.
// PARAMETERS
//  IMEM_WORDS    512  instruction memory depth in 32-bit words (byte addr stride 4)
//  CYC_W         32   width of cycle counter and budget
//  DRAIN_CYCLES  4    extra enabled cycles after stop so IF..WB retire (pipe depth - 1)
// PORTS
//  clk         in   1      clock, all state on rising edge
//  arst_n      in   1      asynchronous active-low reset
//  start       in   1      pulse; accepted only in IDLE or DONE
//  load_len    in   10     number of program words to load; 0 = skip load
//  ld_valid    in   1      program word valid
//  ld_data     in   32     program word
//  ld_ready    out  1      controller accepts ld_data this cycle
//  halt        in   1      stop request from host/monitor, sampled in RUN
//  max_cycles  in   CYC_W  run budget in enabled cycles; 0 = unbounded
//  cpu_rst_n   out  1      to cpu arst_n (ANDed with system reset outside)
//  cpu_enable  out  1      to cpu enable
//  imem_addr   out  64     to cpu addr_ext (byte address)
//  imem_wen    out  1      to cpu wen_ext
//  imem_wdata  out  32     to cpu wdata_ext
//  busy        out  1      high in LOAD/RST/RUN/DRAIN
//  done        out  1      high in DONE, held until next start
//  timeout     out  1      run ended by budget; valid while done
//  cycle_count out  CYC_W  enabled cycles in RUN+DRAIN, saturating at all-ones
// BEHAVIOUR
//  - Reset (async): state IDLE; every output 0 except cpu_rst_n=1; counters and word index 0.
//  - All outputs registered; state is one-hot-safe enum IDLE,LOAD,RST,RUN,DRAIN,DONE.
//  - IDLE/DONE + start: clear done, timeout, cycle_count, word index; latch
//    len = min(load_len, IMEM_WORDS); go LOAD if len>0 else RST. start elsewhere ignored.
//  - LOAD: ld_ready=1 while idx<len. On ld_valid&&ld_ready: next cycle imem_wen=1,
//    imem_addr=idx*4, imem_wdata=ld_data; idx++. ld_ready low in the cycle after the last
//    accept. After the last write cycle -> RST. ld_valid without ready is ignored.
//  - RST: cpu_rst_n=0 for exactly 1 cycle (clears PC/pipeline/regs), cpu_enable=0 -> RUN.
//  - RUN: cpu_enable=1; cycle_count++ per cycle. Exit to DRAIN when halt=1, or when
//    max_cycles!=0 and cycle_count+1==max_cycles (timeout set). Both same cycle: halt
//    wins, timeout=0. halt asserted outside RUN is ignored.
//  - DRAIN: cpu_enable=1 for DRAIN_CYCLES cycles, cycle_count keeps counting -> DONE.
//  - DONE: cpu_enable=0, busy=0, done=1; imem port idle so host may dump memories.
//  - cycle_count saturates; never wraps. idx is 10 bits, len 512 reaches idx=512 exactly.
//  - imem_wen never asserted outside LOAD; cpu_enable never asserted with imem_wen.
//  - Reset mid-LOAD/RUN: immediate return to IDLE, imem_wen and cpu_enable drop async.
// STRUCTURE
//  - Package cpu_ctrl_pkg: state enum, DRAIN_CYCLES default, IMEM word stride constant 4.
//  - One sub-module: sat_counter (CYC_W, clear, inc, saturate) for cycle_count;
//    drain counter and word index stay inline.
// TESTING
//  1 Load 3 words (0x00500093,0x00A00113,0x002081B3), back-to-back valid -> imem writes
//    at addr 0,4,8 on consecutive cycles, ld_ready low after 3rd accept, 1-cycle cpu_rst_n=0.
//  2 Run with halt pulsed at cycle 10 of RUN, max_cycles=0 -> cpu_enable high 14 cycles
//    (10+4 drain), done=1, timeout=0, cycle_count=14.
//  3 max_cycles=20, no halt -> DRAIN entered after 20 RUN cycles, timeout=1, cycle_count=24.
//  4 halt and budget hit same cycle (max_cycles=5, halt at 5th cycle) -> timeout=0.
//  5 load_len=0 then start -> no imem_wen, RST then RUN; start during RUN ignored;
//    load_len=600 clamps to 512 words, last write addr 0x7FC.
//  6 arst_n low mid-LOAD (after 2 of 4 words) -> outputs zero immediately, state IDLE,
//    next start reloads from addr 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the host-side run controller of the 5-stage RISC-V core.
package cpu_ctrl_pkg;

   // One-hot encoding so a corrupted state vector is easy to detect and recover from.
   typedef enum logic [5:0] {
      S_IDLE  = 6'b000001,
      S_LOAD  = 6'b000010,
      S_RST   = 6'b000100,
      S_RUN   = 6'b001000,
      S_DRAIN = 6'b010000,
      S_DONE  = 6'b100000
   } state_e;

   localparam int DRAIN_CYCLES_DEF = 4;
   localparam int IMEM_STRIDE      = 4;
   localparam int LEN_W            = 10;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n, input int max_words);
      return (int'(n) > max_words) ? LEN_W'(max_words) : n;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Sequencer that loads a program into the core's instruction memory, pulses the core
// reset, runs it until halt or budget, drains the pipeline and reports the cycle count.
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int IMEM_WORDS   = 512,
   parameter int CYC_W        = 32,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] load_len,
   input  logic             ld_valid,
   input  logic [31:0]      ld_data,
   output logic             ld_ready,
   input  logic             halt,
   input  logic [CYC_W-1:0] max_cycles,
   output logic             cpu_rst_n,
   output logic             cpu_enable,
   output logic [63:0]      imem_addr,
   output logic             imem_wen,
   output logic [31:0]      imem_wdata,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CYC_W-1:0] cycle_count
);

   localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;

   state_e             r_state;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_idx;
   logic [DRAIN_W-1:0] r_drain_cnt;
   logic               r_ld_ready;
   logic               r_cpu_rst_n;
   logic               r_cpu_enable;
   logic [63:0]        r_imem_addr;
   logic               r_imem_wen;
   logic [31:0]        r_imem_wdata;
   logic               r_busy;
   logic               r_done;
   logic               r_timeout;

   logic               w_start_ok;
   logic               w_accept;
   logic               w_budget_hit;
   logic [LEN_W-1:0]   w_len;
   logic [CYC_W-1:0]   w_count;

   assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_accept     = ld_valid && r_ld_ready;
   assign w_len        = clamp_len(load_len, IMEM_WORDS);
   // The count lags the current enabled cycle by one, hence the +1 against the budget.
   assign w_budget_hit = (max_cycles != '0) && ((w_count + CYC_W'(1)) == max_cycles);

   // Counting on the registered enable makes the count exactly the enabled cycles seen by the core.
   sat_counter #(.W(CYC_W)) u_cycle_cnt (
      .clk     (clk),
      .arst_n  (arst_n),
      .i_clr   (w_start_ok),
      .i_inc   (r_cpu_enable),
      .o_count (w_count)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_idx        <= '0;
         r_drain_cnt  <= '0;
         r_ld_ready   <= 1'b0;
         r_cpu_rst_n  <= 1'b1;
         r_cpu_enable <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wen   <= 1'b0;
         r_imem_wdata <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_ok) begin
                  r_done    <= 1'b0;
                  r_timeout <= 1'b0;
                  r_idx     <= '0;
                  r_len     <= w_len;
                  r_busy    <= 1'b1;
                  if (w_len != '0) begin
                     r_state    <= S_LOAD;
                     r_ld_ready <= 1'b1;
                  end else begin
                     r_state     <= S_RST;
                     r_cpu_rst_n <= 1'b0;
                  end
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_imem_wen   <= 1'b1;
                  r_imem_addr  <= 64'(r_idx) * 64'(IMEM_STRIDE);
                  r_imem_wdata <= ld_data;
                  r_idx        <= r_idx + LEN_W'(1);
                  r_ld_ready   <= (r_idx + LEN_W'(1)) < r_len;
               end else begin
                  r_imem_wen <= 1'b0;
                  // Reaching len with no accept means the last write is on the port right now.
                  if (r_idx == r_len) begin
                     r_state      <= S_RST;
                     r_cpu_rst_n  <= 1'b0;
                     r_imem_addr  <= '0;
                     r_imem_wdata <= '0;
                  end
               end
            end
            S_RST: begin
               r_cpu_rst_n  <= 1'b1;
               r_cpu_enable <= 1'b1;
               r_state      <= S_RUN;
            end
            S_RUN: begin
               if (halt) begin
                  r_state     <= S_DRAIN;
                  r_drain_cnt <= '0;
               end else if (w_budget_hit) begin
                  r_state     <= S_DRAIN;
                  r_drain_cnt <= '0;
                  r_timeout   <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                  r_state      <= S_DONE;
                  r_cpu_enable <= 1'b0;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_ld_ready   <= 1'b0;
               r_cpu_rst_n  <= 1'b1;
               r_cpu_enable <= 1'b0;
               r_imem_wen   <= 1'b0;
               r_busy       <= 1'b0;
               r_done       <= 1'b0;
               r_timeout    <= 1'b0;
            end
         endcase
      end
   end

   assign ld_ready    = r_ld_ready;
   assign cpu_rst_n   = r_cpu_rst_n;
   assign cpu_enable  = r_cpu_enable;
   assign imem_addr   = r_imem_addr;
   assign imem_wen    = r_imem_wen;
   assign imem_wdata  = r_imem_wdata;
   assign busy        = r_busy;
   assign done        = r_done;
   assign timeout     = r_timeout;
   assign cycle_count = w_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: imem writes and run results are checked against scoreboards.
module tb_cpu_run_ctrl;

   localparam int CYC_W     = 32;
   localparam int RUN_LIMIT = 2000;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int cycles;
      bit tmo;
   } res_t;

   logic             clk;
   logic             arst_n;
   logic             start;
   logic [9:0]       load_len;
   logic             ld_valid;
   logic [31:0]      ld_data;
   logic             ld_ready;
   logic             halt;
   logic [CYC_W-1:0] max_cycles;
   logic             cpu_rst_n;
   logic             cpu_enable;
   logic [63:0]      imem_addr;
   logic             imem_wen;
   logic [31:0]      imem_wdata;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [CYC_W-1:0] cycle_count;

   int   n_checks = 0;
   int   n_fail   = 0;
   wr_t  exp_q[$];
   res_t res_q[$];

   cpu_run_ctrl #(.IMEM_WORDS(512), .CYC_W(CYC_W), .DRAIN_CYCLES(4)) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .start       (start),
      .load_len    (load_len),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .halt        (halt),
      .max_cycles  (max_cycles),
      .cpu_rst_n   (cpu_rst_n),
      .cpu_enable  (cpu_enable),
      .imem_addr   (imem_addr),
      .imem_wen    (imem_wen),
      .imem_wdata  (imem_wdata),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .cycle_count (cycle_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_of(input int i);
      case (i)
         0:       return 32'h00500093;
         1:       return 32'h00A00113;
         2:       return 32'h002081B3;
         default: return 32'hC0DE_0000 ^ 32'(i);
      endcase
   endfunction

   // Every write seen on the imem port must match the next expected word.
   always @(negedge clk) begin : mon
      wr_t w;
      if (imem_wen === 1'b1) begin
         check("en_with_wen", cpu_enable, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_wen", imem_wen, 0);
         end else begin
            w = exp_q.pop_front();
            check("wr_addr", imem_addr, w.addr);
            check("wr_data", imem_wdata, w.data);
         end
      end
   end

   task automatic start_cmd(input int len, input int maxc, input int exp_cycles, input bit exp_to);
      res_t r;
      r.cycles   = exp_cycles;
      r.tmo      = exp_to;
      res_q.push_back(r);
      load_len   = 10'(len);
      max_cycles = CYC_W'(maxc);
      start      = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("done_cleared", done, 0);
      check("count_cleared", cycle_count, 0);
   endtask

   task automatic load_words(input int n);
      for (int i = 0; i < n; i++) begin
         if (i > 0) check("wen_back2back", imem_wen, 1);
         check("ld_ready_load", ld_ready, 1);
         ld_valid = 1'b1;
         ld_data  = word_of(i);
         exp_q.push_back({64'(i * 4), word_of(i)});
         tick();
      end
      ld_valid = 1'b0;
   endtask

   // Enter with load finished and the last write on the port; a stray valid must be ignored.
   task automatic finish_load_and_reset();
      check("ld_ready_after_last", ld_ready, 0);
      check("last_write_active", imem_wen, 1);
      ld_valid = 1'b1;
      ld_data  = 32'hDEAD_BEEF;
      tick();
      ld_valid = 1'b0;
      check("cpu_rst_pulse", cpu_rst_n, 0);
      check("enable_in_rst", cpu_enable, 0);
      tick();
      check("cpu_rst_release", cpu_rst_n, 1);
      check("enable_in_run", cpu_enable, 1);
   endtask

   task automatic no_load_reset();
      check("ld_ready_noload", ld_ready, 0);
      check("cpu_rst_noload", cpu_rst_n, 0);
      tick();
      check("cpu_rst_release_noload", cpu_rst_n, 1);
      check("enable_noload", cpu_enable, 1);
   endtask

   task automatic do_run(input int halt_at, input int start_at);
      int   en_cycles;
      bit   ok;
      res_t r;
      en_cycles = 0;
      ok        = 1'b0;
      for (int c = 1; c <= RUN_LIMIT; c++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (cpu_enable === 1'b1) en_cycles++;
         halt  = (c == halt_at);
         start = (c == start_at);
         tick();
      end
      halt  = 1'b0;
      start = 1'b0;
      check("run_done_seen", 64'(ok), 1);
      r = res_q.pop_front();
      check("enabled_cycles", 64'(en_cycles), 64'(r.cycles));
      check("cycle_count", cycle_count, 64'(r.cycles));
      check("timeout", timeout, 64'(r.tmo));
      check("busy_in_done", busy, 0);
      check("enable_in_done", cpu_enable, 0);
   endtask

   initial begin
      arst_n     = 1'b0;
      start      = 1'b0;
      load_len   = '0;
      ld_valid   = 1'b0;
      ld_data    = '0;
      halt       = 1'b0;
      max_cycles = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_cpu_rst_n", cpu_rst_n, 1);
      check("rst_cpu_enable", cpu_enable, 0);
      check("rst_imem_wen", imem_wen, 0);
      check("rst_ld_ready", ld_ready, 0);
      check("rst_cycle_count", cycle_count, 0);
      check("rst_imem_addr", imem_addr, 0);
      #1 arst_n = 1'b1;
      tick();

      // Three-word program, halt at RUN cycle 10, unbounded budget.
      start_cmd(3, 0, 14, 1'b0);
      load_words(3);
      finish_load_and_reset();
      halt = 1'b1;
      do_run(10, 0);
      check("done_held", done, 1);

      // Budget of 20 with no halt; a start during RUN must be ignored.
      start_cmd(0, 20, 24, 1'b1);
      no_load_reset();
      do_run(0, 3);

      // Halt and budget in the same cycle: halt wins.
      start_cmd(0, 5, 9, 1'b0);
      no_load_reset();
      do_run(5, 0);

      // Oversized load clamps to the full memory.
      start_cmd(600, 0, 6, 1'b0);
      load_words(512);
      check("clamp_last_addr", imem_addr, 64'h7FC);
      finish_load_and_reset();
      do_run(2, 0);

      // Reset in the middle of a load, then reload from address 0.
      start_cmd(4, 0, 0, 1'b0);
      load_words(2);
      @(negedge clk);
      #1 arst_n = 1'b0;
      #1;
      check("arst_wen", imem_wen, 0);
      check("arst_enable", cpu_enable, 0);
      check("arst_ld_ready", ld_ready, 0);
      check("arst_busy", busy, 0);
      check("arst_cpu_rst_n", cpu_rst_n, 1);
      res_q.delete();
      #1 arst_n = 1'b1;
      tick();
      start_cmd(4, 0, 5, 1'b0);
      load_words(4);
      finish_load_and_reset();
      do_run(1, 0);

      check("writes_pending", 64'(exp_q.size()), 0);
      check("results_pending", 64'(res_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
